// File: rtl/ddr_sched_pkg.sv
// Shared types and helpers for the DDR burst scheduler.
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    WR   = 3'd2,
    RD   = 3'd3,
    UPD  = 3'd4
  } sched_state_t;

  localparam int RR_MAX = 32;

  // First requesting index at or after ptr, wrapping modulo n (n <= RR_MAX).
  function automatic int rr_next_idx(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    int idx;
    int pick;
    pick = ptr;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from ptr upward for a requester.
module rr_arbiter
  import ddr_sched_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [RR_MAX-1:0] req_ext_s;

  // Round-robin selection and one-hot grant.
  always_comb begin
    req_ext_s         = '0;
    req_ext_s[N-1:0]  = req;
    idx               = IDX_W'(rr_next_idx(req_ext_s, int'(ptr), N));
    valid             = |req;
    grant             = '0;
    if (valid) begin
      grant[idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/ddr_burst_sched.sv
// Multi-channel write/read burst scheduler in front of ddr_ctrl.
// Optional macro PINGPONG_EN gives each channel two alternating frame banks.
module ddr_burst_sched
  import ddr_sched_pkg::*;
#(
  parameter int CH_NUM      = 2,
  parameter int ADDR_W      = 25,
  parameter int LEN_W       = 10,
  parameter int BURST_LEN   = 256,
  parameter int LVL_W       = 11,
  parameter int FRAME_WORDS = 393216
) (
  input  logic                    clk_ref,
  input  logic                    rst,
  input  logic                    ddr_init_done,
  input  logic [CH_NUM-1:0]       wr_load,
  input  logic [CH_NUM-1:0]       rd_load,
  input  logic [CH_NUM*LVL_W-1:0] wrf_level,
  input  logic [CH_NUM*LVL_W-1:0] rdf_space,
  input  logic [CH_NUM-1:0]       rd_enable,
  output logic                    wr_burst_req,
  output logic [ADDR_W-1:0]       wr_burst_addr,
  output logic [LEN_W-1:0]        wr_burst_len,
  input  logic                    wr_burst_finish,
  output logic                    rd_burst_req,
  output logic [ADDR_W-1:0]       rd_burst_addr,
  output logic [LEN_W-1:0]        rd_burst_len,
  input  logic                    rd_burst_finish,
  output logic [CH_NUM-1:0]       wr_grant,
  output logic [CH_NUM-1:0]       rd_grant,
  output logic [CH_NUM-1:0]       frame_write_done,
  output logic [CH_NUM-1:0]       frame_read_done
);

  localparam int                IDX_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [IDX_W-1:0]  LAST_CH = IDX_W'(CH_NUM - 1);
  localparam logic [ADDR_W-1:0] FW_A    = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BL_A    = ADDR_W'(BURST_LEN);
  localparam logic [LVL_W:0]    BL_LVL  = (LVL_W + 1)'(BURST_LEN);

  sched_state_t      state_r;
  logic              pref_wr_r, cur_wr_r;
  logic [IDX_W-1:0]  cur_ch_r, wr_ptr_r, rd_ptr_r;
  logic [ADDR_W-1:0] wr_off_r [CH_NUM];
  logic [ADDR_W-1:0] rd_off_r [CH_NUM];
  logic [CH_NUM-1:0] wr_pend_r, rd_pend_r;
`ifdef PINGPONG_EN
  logic [CH_NUM-1:0] wr_bank_r, rd_bank_r, frame_valid_r;
  logic              rd_bank_s;
`endif

  logic [CH_NUM-1:0] wr_elig_s, rd_elig_s, wr_gnt_s, rd_gnt_s;
  logic [CH_NUM-1:0] wr_act_s, rd_act_s, cur_oh_s;
  logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;
  logic              wr_valid_s, rd_valid_s, go_wr_s, go_rd_s, wr_wrap_s, rd_wrap_s;
  logic [ADDR_W-1:0] wr_addr_s, rd_addr_s, wr_new_s, rd_new_s;

  // Per-channel eligibility from fifo fill levels.
  always_comb begin
    wr_elig_s = '0;
    rd_elig_s = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      wr_elig_s[i] = {1'b0, wrf_level[i*LVL_W +: LVL_W]} >= BL_LVL;
      rd_elig_s[i] = rd_enable[i] && ({1'b0, rdf_space[i*LVL_W +: LVL_W]} >= BL_LVL);
    end
  end

  rr_arbiter #(.N(CH_NUM), .IDX_W(IDX_W)) u_wr_arb (
    .req(wr_elig_s), .ptr(wr_ptr_r), .grant(wr_gnt_s), .idx(wr_idx_s), .valid(wr_valid_s)
  );

  rr_arbiter #(.N(CH_NUM), .IDX_W(IDX_W)) u_rd_arb (
    .req(rd_elig_s), .ptr(rd_ptr_r), .grant(rd_gnt_s), .idx(rd_idx_s), .valid(rd_valid_s)
  );

  // Type choice, burst addresses and which channel a load would collide with.
  always_comb begin
    go_wr_s   = ddr_init_done && wr_valid_s && (pref_wr_r || !rd_valid_s);
    go_rd_s   = ddr_init_done && rd_valid_s && !go_wr_s;
    wr_new_s  = wr_off_r[cur_ch_r] + BL_A;
    rd_new_s  = rd_off_r[cur_ch_r] + BL_A;
    wr_wrap_s = (wr_new_s == FW_A);
    rd_wrap_s = (rd_new_s == FW_A);
`ifdef PINGPONG_EN
    rd_bank_s = (rd_off_r[rd_idx_s] == '0) ? (frame_valid_r[rd_idx_s] & ~wr_bank_r[rd_idx_s])
                                            : rd_bank_r[rd_idx_s];
    wr_addr_s = ADDR_W'({wr_idx_s, wr_bank_r[wr_idx_s]}) * FW_A + wr_off_r[wr_idx_s];
    rd_addr_s = ADDR_W'({rd_idx_s, rd_bank_s}) * FW_A + rd_off_r[rd_idx_s];
`else
    wr_addr_s = ADDR_W'(wr_idx_s) * FW_A + wr_off_r[wr_idx_s];
    rd_addr_s = ADDR_W'(rd_idx_s) * FW_A + rd_off_r[rd_idx_s];
`endif
    cur_oh_s           = '0;
    cur_oh_s[cur_ch_r] = 1'b1;
    wr_act_s           = '0;
    rd_act_s           = '0;
    case (state_r)
      ARB: begin
        if (go_wr_s) wr_act_s = wr_gnt_s;
        else if (go_rd_s) rd_act_s = rd_gnt_s;
        else wr_act_s = '0;
      end
      WR: wr_act_s = cur_oh_s;
      RD: rd_act_s = cur_oh_s;
      UPD: begin
        if (cur_wr_r) wr_act_s = cur_oh_s;
        else rd_act_s = cur_oh_s;
      end
      default: wr_act_s = '0;
    endcase
  end

  // Scheduler FSM, offsets and registered burst-port outputs.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      pref_wr_r        <= 1'b1;
      cur_wr_r         <= 1'b0;
      cur_ch_r         <= '0;
      wr_ptr_r         <= '0;
      rd_ptr_r         <= '0;
      wr_pend_r        <= '0;
      rd_pend_r        <= '0;
      wr_burst_req     <= 1'b0;
      wr_burst_addr    <= '0;
      wr_burst_len     <= '0;
      rd_burst_req     <= 1'b0;
      rd_burst_addr    <= '0;
      rd_burst_len     <= '0;
      wr_grant         <= '0;
      rd_grant         <= '0;
      frame_write_done <= '0;
      frame_read_done  <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        wr_off_r[i] <= '0;
        rd_off_r[i] <= '0;
      end
`ifdef PINGPONG_EN
      wr_bank_r     <= '0;
      rd_bank_r     <= '0;
      frame_valid_r <= '0;
`endif
    end else begin
      frame_write_done <= '0;
      frame_read_done  <= '0;
      // Loads on a channel in flight are deferred to UPD so the burst address stays consistent.
      for (int i = 0; i < CH_NUM; i++) begin
        if (wr_load[i]) begin
          if (wr_act_s[i]) wr_pend_r[i] <= 1'b1;
          else wr_off_r[i] <= '0;
        end
        if (rd_load[i]) begin
          if (rd_act_s[i]) rd_pend_r[i] <= 1'b1;
          else rd_off_r[i] <= '0;
        end
      end
      case (state_r)
        IDLE: begin
          if (ddr_init_done) state_r <= ARB;
        end
        ARB: begin
          if (!ddr_init_done) begin
            state_r <= IDLE;
          end else if (go_wr_s) begin
            state_r       <= WR;
            cur_wr_r      <= 1'b1;
            cur_ch_r      <= wr_idx_s;
            wr_burst_req  <= 1'b1;
            wr_burst_addr <= wr_addr_s;
            wr_burst_len  <= LEN_W'(BURST_LEN);
            wr_grant      <= wr_gnt_s;
          end else if (go_rd_s) begin
            state_r       <= RD;
            cur_wr_r      <= 1'b0;
            cur_ch_r      <= rd_idx_s;
            rd_burst_req  <= 1'b1;
            rd_burst_addr <= rd_addr_s;
            rd_burst_len  <= LEN_W'(BURST_LEN);
            rd_grant      <= rd_gnt_s;
`ifdef PINGPONG_EN
            rd_bank_r[rd_idx_s] <= rd_bank_s;
`endif
          end
        end
        WR: begin
          if (wr_burst_finish) begin
            wr_burst_req <= 1'b0;
            wr_grant     <= '0;
            state_r      <= UPD;
          end
        end
        RD: begin
          if (rd_burst_finish) begin
            rd_burst_req <= 1'b0;
            rd_grant     <= '0;
            state_r      <= UPD;
          end
        end
        UPD: begin
          state_r   <= ddr_init_done ? ARB : IDLE;
          // Prefer the type not just served, so both sides alternate under load.
          pref_wr_r <= ~cur_wr_r;
          if (cur_wr_r) begin
            wr_pend_r[cur_ch_r]        <= 1'b0;
            wr_off_r[cur_ch_r]         <= (wr_wrap_s || wr_pend_r[cur_ch_r] || wr_load[cur_ch_r]) ? '0 : wr_new_s;
            frame_write_done[cur_ch_r] <= wr_wrap_s;
            wr_ptr_r                   <= (cur_ch_r == LAST_CH) ? '0 : cur_ch_r + 1'b1;
`ifdef PINGPONG_EN
            if (wr_wrap_s) begin
              wr_bank_r[cur_ch_r]     <= ~wr_bank_r[cur_ch_r];
              frame_valid_r[cur_ch_r] <= 1'b1;
            end
`endif
          end else begin
            rd_pend_r[cur_ch_r]       <= 1'b0;
            rd_off_r[cur_ch_r]        <= (rd_wrap_s || rd_pend_r[cur_ch_r] || rd_load[cur_ch_r]) ? '0 : rd_new_s;
            frame_read_done[cur_ch_r] <= rd_wrap_s;
            rd_ptr_r                  <= (cur_ch_r == LAST_CH) ? '0 : cur_ch_r + 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
